// File: rtl/codec_stream_pkg.sv
// Shared types and constants for the codec sample stream bridge.
// States are plain 2-bit constants so legacy code can keep comparing raw codes.
package codec_stream_pkg;

  localparam int unsigned DW_DEFAULT = 24;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_PRIME = 2'd1;
  localparam state_t S_RUN   = 2'd2;

  localparam logic [DW_DEFAULT-1:0] MUTE_SAMPLE = '0;

endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: synchronous first-word fall-through FIFO.
// Ports:
//   clk, rst_ni         clock, async active-low reset
//   flush_i             synchronous empty (wins over push)
//   push_i / wdata_i    write request and data; accepted when not full or popping
//   pop_i               read request; ignored when empty
//   rdata_o             head entry (0 when empty)
//   full_o, empty_o     status
//   level_o             occupancy, wptr - rptr
module sample_fifo #(
  parameter int unsigned DW    = 24,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [DW-1:0]            wdata_i,
  output logic [DW-1:0]            rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [LW-1:0] r_wptr;
  logic [LW-1:0] r_rptr;
  logic          w_pop;
  logic          w_push;

  assign empty_o = (r_wptr == r_rptr);
  assign full_o  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign level_o = r_wptr - r_rptr;
  // Head is forced to 0 when empty so nothing uninitialised leaks out.
  assign rdata_o = empty_o ? '0 : r_mem[r_rptr[AW-1:0]];

  // A push into a full FIFO only succeeds when the head leaves in the same cycle.
  assign w_pop  = pop_i && !empty_o && !flush_i;
  assign w_push = push_i && (!full_o || w_pop) && !flush_i;

  // Pointer update
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (flush_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + LW'(1);
      if (w_pop)  r_rptr <= r_rptr + LW'(1);
    end
  end

  // Storage
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/codec_sample_stream_bridge.sv
// codec_sample_stream_bridge: elastic bridge between the codec parallel sample
// port (one clk_sample edge per LRCK frame) and valid/ready DSP streams.
// Ports:
//   clk_sample, rst_ni          frame clock, async active-low reset
//   en_i                        stream enable
//   sample_from_linein_i        captured line-in sample
//   data_to_lineout_o           registered line-out sample
//   load_o                      codec run/load strobe
//   rx_data_o/valid_o/ready_i   line-in stream (first-word fall-through)
//   tx_data_i/valid_i/ready_o   line-out stream
//   tx_level_o                  TX FIFO occupancy
//   clr_status_i                clears sticky flags (a same-cycle event wins)
//   rx_overrun_o, tx_underrun_o sticky status
// Build option: define CODEC_STREAM_HOLD_ON_UNDERRUN_EN to hold the last
// line-out sample on underrun instead of muting.
module codec_sample_stream_bridge
  import codec_stream_pkg::*;
#(
  parameter int unsigned DW          = DW_DEFAULT,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned PRIME_LEVEL = 2
) (
  input  logic                   clk_sample,
  input  logic                   rst_ni,
  input  logic                   en_i,
  input  logic [DW-1:0]          sample_from_linein_i,
  output logic [DW-1:0]          data_to_lineout_o,
  output logic                   load_o,
  output logic [DW-1:0]          rx_data_o,
  output logic                   rx_valid_o,
  input  logic                   rx_ready_i,
  input  logic [DW-1:0]          tx_data_i,
  input  logic                   tx_valid_i,
  output logic                   tx_ready_o,
  output logic [$clog2(DEPTH):0] tx_level_o,
  input  logic                   clr_status_i,
  output logic                   rx_overrun_o,
  output logic                   tx_underrun_o
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;
  localparam logic [DW-1:0] MUTE = DW'(MUTE_SAMPLE);

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_load;
  logic          w_load_nxt;
  logic          r_first;
  logic          r_alive;
  logic [DW-1:0] r_lineout;
  logic [DW-1:0] w_lineout_nxt;
  logic          r_rx_overrun;
  logic          r_tx_underrun;

  logic          w_to_idle;
  logic          w_rx_push;
  logic          w_rx_pop;
  logic          w_rx_full;
  logic          w_rx_empty;
  logic          w_rx_drop;
  logic [LW-1:0] w_rx_level_unused;
  logic          w_tx_push;
  logic          w_tx_pop;
  logic          w_tx_full;
  logic          w_tx_empty;
  logic [DW-1:0] w_tx_rdata;
  logic [LW-1:0] w_tx_level;
  logic          w_underrun;

  // Leaving PRIME/RUN because enable dropped: flush both FIFOs this edge.
  assign w_to_idle = (r_state != S_IDLE) && !en_i;

  // The first loaded edge still carries the previous, unloaded frame's sample.
  assign w_rx_push = r_load && !r_first && !w_to_idle;
  assign w_rx_pop  = !w_rx_empty && rx_ready_i;
  assign w_rx_drop = w_rx_push && w_rx_full && !w_rx_pop;

  assign w_tx_push  = tx_valid_i && tx_ready_o;
  assign w_tx_pop   = (r_state == S_RUN) && en_i && !w_tx_empty;
  assign w_underrun = (r_state == S_RUN) && en_i && w_tx_empty;

  sample_fifo #(.DW(DW), .DEPTH(DEPTH)) u_rx_fifo (
    .clk     (clk_sample),
    .rst_ni  (rst_ni),
    .flush_i (w_to_idle),
    .push_i  (w_rx_push),
    .pop_i   (w_rx_pop),
    .wdata_i (sample_from_linein_i),
    .rdata_o (rx_data_o),
    .full_o  (w_rx_full),
    .empty_o (w_rx_empty),
    .level_o (w_rx_level_unused)
  );

  sample_fifo #(.DW(DW), .DEPTH(DEPTH)) u_tx_fifo (
    .clk     (clk_sample),
    .rst_ni  (rst_ni),
    .flush_i (w_to_idle),
    .push_i  (w_tx_push),
    .pop_i   (w_tx_pop),
    .wdata_i (tx_data_i),
    .rdata_o (w_tx_rdata),
    .full_o  (w_tx_full),
    .empty_o (w_tx_empty),
    .level_o (w_tx_level)
  );

  assign rx_valid_o        = !w_rx_empty;
  // r_alive keeps ready low while reset is asserted and until the first edge after it.
  assign tx_ready_o        = r_alive && !w_tx_full;
  assign tx_level_o        = w_tx_level;
  assign load_o            = r_load;
  assign data_to_lineout_o = r_lineout;
  assign rx_overrun_o      = r_rx_overrun;
  assign tx_underrun_o     = r_tx_underrun;

  // State register
  always_ff @(posedge clk_sample or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next state and next registered outputs
  always_comb begin
    w_state_nxt   = r_state;
    w_load_nxt    = 1'b0;
    w_lineout_nxt = r_lineout;
    case (r_state)
      S_IDLE: begin
        w_lineout_nxt = MUTE;
        if (en_i) w_state_nxt = S_PRIME;
      end
      S_PRIME: begin
        w_load_nxt    = 1'b1;
        w_lineout_nxt = MUTE;
        if (w_tx_level >= LW'(PRIME_LEVEL)) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_load_nxt = 1'b1;
        if (!w_tx_empty) begin
          w_lineout_nxt = w_tx_rdata;
        end else begin
`ifdef CODEC_STREAM_HOLD_ON_UNDERRUN_EN
          w_lineout_nxt = r_lineout;
`else
          w_lineout_nxt = MUTE;
`endif
        end
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_lineout_nxt = MUTE;
      end
    endcase
    if (w_to_idle) begin
      w_state_nxt   = S_IDLE;
      w_load_nxt    = 1'b0;
      w_lineout_nxt = MUTE;
    end
  end

  // Registered outputs, capture-skip tracking and sticky status
  always_ff @(posedge clk_sample or negedge rst_ni) begin
    if (!rst_ni) begin
      r_load        <= 1'b0;
      r_first       <= 1'b1;
      r_alive       <= 1'b0;
      r_lineout     <= '0;
      r_rx_overrun  <= 1'b0;
      r_tx_underrun <= 1'b0;
    end else begin
      r_load        <= w_load_nxt;
      r_first       <= !r_load;
      r_alive       <= 1'b1;
      r_lineout     <= w_lineout_nxt;
      r_rx_overrun  <= w_rx_drop  || (r_rx_overrun  && !clr_status_i);
      r_tx_underrun <= w_underrun || (r_tx_underrun && !clr_status_i);
    end
  end

endmodule

// File: tb/tb_codec_sample_stream_bridge.sv
// Directed bench for codec_sample_stream_bridge (DW=24, DEPTH=8, PRIME_LEVEL=2).
module tb_codec_sample_stream_bridge;

  logic        clk_sample = 1'b0;
  logic        rst_ni;
  logic        en_i;
  logic [23:0] sample_from_linein_i;
  logic [23:0] data_to_lineout_o;
  logic        load_o;
  logic [23:0] rx_data_o;
  logic        rx_valid_o;
  logic        rx_ready_i;
  logic [23:0] tx_data_i;
  logic        tx_valid_i;
  logic        tx_ready_o;
  logic [3:0]  tx_level_o;
  logic        clr_status_i;
  logic        rx_overrun_o;
  logic        tx_underrun_o;

  int n_cmp = 0;
  int n_err = 0;

  codec_sample_stream_bridge #(.DW(24), .DEPTH(8), .PRIME_LEVEL(2)) dut (
    .clk_sample           (clk_sample),
    .rst_ni               (rst_ni),
    .en_i                 (en_i),
    .sample_from_linein_i (sample_from_linein_i),
    .data_to_lineout_o    (data_to_lineout_o),
    .load_o               (load_o),
    .rx_data_o            (rx_data_o),
    .rx_valid_o           (rx_valid_o),
    .rx_ready_i           (rx_ready_i),
    .tx_data_i            (tx_data_i),
    .tx_valid_i           (tx_valid_i),
    .tx_ready_o           (tx_ready_o),
    .tx_level_o           (tx_level_o),
    .clr_status_i         (clr_status_i),
    .rx_overrun_o         (rx_overrun_o),
    .tx_underrun_o        (tx_underrun_o)
  );

  always #5 clk_sample = ~clk_sample;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sample);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " load"},     32'(load_o), 32'h0);
    check({tag, " lineout"},  32'(data_to_lineout_o), 32'h0);
    check({tag, " rx_valid"}, 32'(rx_valid_o), 32'h0);
    check({tag, " rx_data"},  32'(rx_data_o), 32'h0);
    check({tag, " tx_ready"}, 32'(tx_ready_o), 32'h0);
    check({tag, " tx_level"}, 32'(tx_level_o), 32'h0);
    check({tag, " overrun"},  32'(rx_overrun_o), 32'h0);
    check({tag, " underrun"}, 32'(tx_underrun_o), 32'h0);
  endtask

  logic [23:0] drain_exp [7];

  initial begin
    rst_ni = 1'b1;
    en_i = 1'b0;
    sample_from_linein_i = '0;
    rx_ready_i = 1'b0;
    tx_data_i = '0;
    tx_valid_i = 1'b0;
    clr_status_i = 1'b0;
    #1 rst_ni = 1'b0;
    #2;
    check_all_zero("reset");
    #9 rst_ni = 1'b1;
    tick();
    check("idle tx_ready", 32'(tx_ready_o), 32'h1);
    check("idle load", 32'(load_o), 32'h0);

    // Basic RX capture: linein = edge index; edge 3 is discarded.
    en_i = 1'b1;
    rx_ready_i = 1'b1;
    sample_from_linein_i = 24'h000001; tick();
    check("rx e1 load", 32'(load_o), 32'h0);
    sample_from_linein_i = 24'h000002; tick();
    check("rx e2 load", 32'(load_o), 32'h1);
    sample_from_linein_i = 24'h000003; tick();
    check("rx e3 discard valid", 32'(rx_valid_o), 32'h0);
    sample_from_linein_i = 24'h000004; tick();
    check("rx e4 valid", 32'(rx_valid_o), 32'h1);
    check("rx e4 data", 32'(rx_data_o), 32'h000004);
    sample_from_linein_i = 24'h000005; tick();
    check("rx e5 data", 32'(rx_data_o), 32'h000005);
    sample_from_linein_i = 24'h000006; tick();
    check("rx e6 data", 32'(rx_data_o), 32'h000006);
    check("prime lineout", 32'(data_to_lineout_o), 32'h0);

    // Priming and playback, then underrun.
    tx_valid_i = 1'b1;
    tx_data_i = 24'hABCDEF; tick();
    check("prime lvl1", 32'(tx_level_o), 32'h1);
    check("prime lvl1 lineout", 32'(data_to_lineout_o), 32'h0);
    tx_data_i = 24'h123456; tick();
    check("prime lvl2", 32'(tx_level_o), 32'h2);
    check("prime lvl2 lineout", 32'(data_to_lineout_o), 32'h0);
    tx_valid_i = 1'b0; tick();
    check("to run lineout", 32'(data_to_lineout_o), 32'h0);
    check("to run level", 32'(tx_level_o), 32'h2);
    tick();
    check("run lineout0", 32'(data_to_lineout_o), 32'hABCDEF);
    check("run level1", 32'(tx_level_o), 32'h1);
    tick();
    check("run lineout1", 32'(data_to_lineout_o), 32'h123456);
    check("run level0", 32'(tx_level_o), 32'h0);
    check("run no underrun", 32'(tx_underrun_o), 32'h0);
    tick();
    check("underrun flag", 32'(tx_underrun_o), 32'h1);
`ifdef CODEC_STREAM_HOLD_ON_UNDERRUN_EN
    check("underrun lineout", 32'(data_to_lineout_o), 32'h123456);
`else
    check("underrun lineout", 32'(data_to_lineout_o), 32'h0);
`endif
    check("no rx overrun", 32'(rx_overrun_o), 32'h0);
    clr_status_i = 1'b1; tick();
    check("clr vs underrun set wins", 32'(tx_underrun_o), 32'h1);
    clr_status_i = 1'b0;

    // Mid-RUN disable with both FIFOs partially full.
    rx_ready_i = 1'b0;
    tx_valid_i = 1'b1;
    tx_data_i = 24'h7FFFFF; tick();
    tx_data_i = 24'h000111; tick();
    check("pre-dis lineout", 32'(data_to_lineout_o), 32'h7FFFFF);
    check("pre-dis tx level", 32'(tx_level_o), 32'h1);
    check("pre-dis rx valid", 32'(rx_valid_o), 32'h1);
    tx_valid_i = 1'b0;
    en_i = 1'b0; tick();
    check("dis load", 32'(load_o), 32'h0);
    check("dis lineout", 32'(data_to_lineout_o), 32'h0);
    check("dis tx level", 32'(tx_level_o), 32'h0);
    check("dis rx valid", 32'(rx_valid_o), 32'h0);
    check("dis underrun kept", 32'(tx_underrun_o), 32'h1);
    check("dis tx ready", 32'(tx_ready_o), 32'h1);
    clr_status_i = 1'b1; tick();
    check("clr underrun", 32'(tx_underrun_o), 32'h0);
    clr_status_i = 1'b0;

    // Re-enable with rx_ready low: 104..111 fill the FIFO, 112..114 dropped.
    en_i = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      sample_from_linein_i = 24'(100 + k);
      tick();
      if (k == 2) check("reen load", 32'(load_o), 32'h1);
      if (k == 2) check("reen prime lineout", 32'(data_to_lineout_o), 32'h0);
      if (k == 11) check("full no overrun", 32'(rx_overrun_o), 32'h0);
      if (k == 12) check("overrun set", 32'(rx_overrun_o), 32'h1);
    end
    check("ovr head", 32'(rx_data_o), 32'h000068);
    // Push+pop while full, plus clear: flag drops.
    rx_ready_i = 1'b1;
    clr_status_i = 1'b1;
    sample_from_linein_i = 24'h000073; tick();
    check("full push+pop clears", 32'(rx_overrun_o), 32'h0);
    check("full push+pop head", 32'(rx_data_o), 32'h000069);
    clr_status_i = 1'b0;
    drain_exp[0] = 24'd106; drain_exp[1] = 24'd107; drain_exp[2] = 24'd108;
    drain_exp[3] = 24'd109; drain_exp[4] = 24'd110; drain_exp[5] = 24'd111;
    drain_exp[6] = 24'd115;
    for (int j = 0; j < 7; j++) begin
      sample_from_linein_i = 24'(116 + j);
      tick();
      check($sformatf("drain %0d", j), 32'(rx_data_o), 32'(drain_exp[j]));
    end
    check("drain no overrun", 32'(rx_overrun_o), 32'h0);

    // Get into RUN with a live sample and an overrun, then async reset mid-frame.
    rx_ready_i = 1'b0;
    tx_valid_i = 1'b1;
    tx_data_i = 24'h0000AA; tick();
    tx_data_i = 24'h0000BB; tick();
    tx_valid_i = 1'b0; tick();
    tick();
    check("pre-rst lineout", 32'(data_to_lineout_o), 32'h0000AA);
    check("pre-rst overrun", 32'(rx_overrun_o), 32'h1);
    check("pre-rst load", 32'(load_o), 32'h1);
    #3 rst_ni = 1'b0;
    #1;
    check_all_zero("async rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
